sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Memory-side responder for the CPU core's instruction and data fetch ports.
- Accepts level-type read/write requests (iread_ce, dread_ce, dwrite_ce) and serves each 32-bit word as two sequential 16-bit accesses to one external asynchronous SRAM: half A (low) first, then half B (high).
- Signals completion per half through the fin strobes the core waits on.
- Sits between the core top and the board SRAM pins; arbitrates the two ports onto the single SRAM.

Parameters:
- WAIT_CYCLES, 2: strobe cycles per half access; minimum 1.
- SRAM_AW, 20: SRAM halfword address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- dread_ce  in  1  data read request, level.
- dwrite_ce  in  1  data write request, level.
- drom_addr  in  32  data byte address.
- wdata  in  32  data write word.
- rom_rdata  out  32  data read word.
- rfin_a / rfin_b  out  1  data read low/high half done, one-cycle pulse.
- wfin_a / wfin_b  out  1  data write low/high half done, one-cycle pulse.
- iread_ce  in  1  instruction read request, level.
- irom_addr  in  32  instruction byte address.
- rom_inst  out  32  instruction word.
- rfin_c / rfin_d  out  1  instruction low/high half done, one-cycle pulse.
- sram_addr  out  SRAM_AW  halfword address.
- sram_wdata  out  16  write data.
- sram_rdata  in  16  read data.
- sram_dq_oe  out  1  data-bus drive enable, for the top-level tristate.
- sram_ce_n / sram_oe_n / sram_we_n  out  1  active-low SRAM strobes.

Behaviour:
- Reset (synchronous, active-high) forces the following on the next edge, including mid-access:
  - state IDLE;
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_dq_oe = 0;
  - all fin outputs 0;
  - rom_rdata = 0, rom_inst = 0, sram_addr = 0, sram_wdata = 0;
  - an interrupted access produces no fin pulse.
- States: IDLE, A_SETUP, A_STROBE, B_SETUP, B_STROBE, DONE. A strobe counter runs 0..WAIT_CYCLES-1.
- IDLE:
  - Samples requests each edge.
  - Priority: dwrite_ce > dread_ce > iread_ce.
  - The winner's address, write data and kind are latched, then the block goes to A_SETUP.
  - Requests raised mid-access wait; there is no preemption.
- Address mapping: sram_addr = {addr[SRAM_AW:2], half}, where half = 0 in A and 1 in B. addr[1:0] is ignored.
- A_SETUP (1 cycle):
  - sram_ce_n = 0, address valid, oe_n/we_n = 1.
  - For writes, sram_dq_oe = 1 and sram_wdata = wdata[15:0].
- A_STROBE (WAIT_CYCLES cycles):
  - Read: oe_n = 0.
  - Write: we_n = 0 and data held.
  - On a read, sram_rdata is captured into the low half of an internal buffer at the last strobe edge.
- B_SETUP (1 cycle) and B_STROBE (WAIT_CYCLES cycles) repeat the A phases for the high half, using wdata[31:16].
- Completion pulses:
  - The kind-matched *fin_a / rfin_c pulses during the B_SETUP cycle.
  - The *fin_b / rfin_d pulses during the first DONE cycle.
- In that same first DONE cycle, rom_rdata or rom_inst updates to the full word. Values are held until the next completed read on that port.
- Latency, with the request sampled at edge 0:
  - fin_a in cycle WAIT_CYCLES+2; fin_b in cycle 2*WAIT_CYCLES+3.
  - With WAIT_CYCLES = 2: cycles 4 and 7.
- DONE: strobes are deasserted; the block returns to IDLE only once the served port's ce is low (for the data port, both dread_ce and dwrite_ce low). A held ce never retriggers a second access.
- Simultaneous dread_ce and dwrite_ce: served as a write only.
- A ce dropped mid-access does not abort the access; completion proceeds and DONE exits immediately.
- There is never an SRAM idle gap between halves. sram_ce_n stays 0 from A_SETUP through B_STROBE.

Optional Feature:
- Macro: SRAM_RESP_IBUF_EN.
- When defined, a one-entry instruction buffer is added, holding the address and word of the last completed instruction read.
- Hit: iread_ce accepted with irom_addr[31:2] equal to the buffered address, and the buffer valid.
  - On a hit, no SRAM access occurs.
  - rfin_c pulses in cycle 1 after acceptance; rom_inst (unchanged) and rfin_d follow in cycle 2, followed by normal DONE handling.
- Invalidation: any data write invalidates the buffer (on acceptance), as does reset.
- When undefined, every instruction read accesses the SRAM.

Test Plan:
- Reset, then dread_ce=1, drom_addr=0x00000008, SRAM returns 0x1111 at addr 4 and 0x2222 at addr 5 (WAIT_CYCLES=2) -> rfin_a in cycle 4, rfin_b in cycle 7, rom_rdata=0x22221111; sram_ce_n low in cycles 1–6.
- dwrite_ce=1, drom_addr=0x10, wdata=0xDEADBEEF -> we_n low with sram_addr=8/data 0xBEEF, then sram_addr=9/data 0xDEAD; sram_dq_oe high in cycles 1–6; wfin_a in cycle 4, wfin_b in cycle 7; wfin strobes only, rfin silent.
- iread_ce and dread_ce raised in the same cycle -> data served first; after dread_ce drops, the instruction access starts; rfin_c/rfin_d follow, ordered after rfin_b.
- ce held high for 20 cycles after completion -> exactly one access and one fin_a/fin_b pair.
- rst asserted in A_STROBE of a write -> next cycle all strobes 1, sram_dq_oe 0, no wfin pulses, state IDLE.
- With SRAM_RESP_IBUF_EN: two reads of irom_addr=0x40 -> the second has no sram_ce_n activity and rfin_d in cycle 2; an intervening data write to any address -> the second read accesses the SRAM.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: serves the core's instruction and data fetch ports from one
// external 16-bit asynchronous SRAM, two halfword accesses per 32-bit word.
// Optional feature macro: SRAM_RESP_IBUF_EN (one-entry instruction buffer).
module sram_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dread_ce,
    input  logic               dwrite_ce,
    input  logic [31:0]        drom_addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rom_rdata,
    output logic               rfin_a,
    output logic               rfin_b,
    output logic               wfin_a,
    output logic               wfin_b,
    input  logic               iread_ce,
    input  logic [31:0]        irom_addr,
    output logic [31:0]        rom_inst,
    output logic               rfin_c,
    output logic               rfin_d,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [2:0]         dbg_state
);
    // Request protocol: a port holds its ce high until it sees its fin_b pulse;
    // the access runs to completion even if ce drops, and a new access on that
    // port starts only after its ce has been seen low in DONE.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_A_SETUP  = 3'd1;
    localparam logic [2:0] S_A_STROBE = 3'd2;
    localparam logic [2:0] S_B_SETUP  = 3'd3;
    localparam logic [2:0] S_B_STROBE = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_HIT      = 3'd6;

    localparam logic [1:0] K_DRD = 2'd0;
    localparam logic [1:0] K_DWR = 2'd1;
    localparam logic [1:0] K_IRD = 2'd2;

    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         kind_q, kind_d;
    logic [29:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [15:0]        lo_q, lo_d;
    logic [31:0]        rom_rdata_q, rom_rdata_d;
    logic [31:0]        rom_inst_q, rom_inst_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]        sram_wdata_q, sram_wdata_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic [5:0]         fin_q, fin_d;     // {rfin_d, rfin_c, wfin_b, wfin_a, rfin_b, rfin_a}
    logic               last_strobe;
    logic               active, strobe, half_b, is_wr, fin_a_ev, fin_b_ev;
`ifdef SRAM_RESP_IBUF_EN
    // rom_inst_q doubles as the buffered word: it always holds the last
    // completed instruction read, which is exactly what a hit returns.
    logic               ibuf_valid_q, ibuf_valid_d;
    logic [29:0]        ibuf_addr_q, ibuf_addr_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{drom_addr[1:0], irom_addr[1:0], addr_q};

    assign last_strobe = (cnt_q == CNT_LAST);

    // Next-state, latching and registered SRAM pin / fin values.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        rom_rdata_d = rom_rdata_q;
        rom_inst_d  = rom_inst_q;
`ifdef SRAM_RESP_IBUF_EN
        ibuf_valid_d = ibuf_valid_q;
        ibuf_addr_d  = ibuf_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (dwrite_ce) begin
                    kind_d  = K_DWR;
                    addr_d  = drom_addr[31:2];
                    wdata_d = wdata;
                    state_d = S_A_SETUP;
`ifdef SRAM_RESP_IBUF_EN
                    ibuf_valid_d = 1'b0;
`endif
                end else if (dread_ce) begin
                    kind_d  = K_DRD;
                    addr_d  = drom_addr[31:2];
                    state_d = S_A_SETUP;
                end else if (iread_ce) begin
                    kind_d  = K_IRD;
                    addr_d  = irom_addr[31:2];
`ifdef SRAM_RESP_IBUF_EN
                    if (ibuf_valid_q && (irom_addr[31:2] == ibuf_addr_q)) state_d = S_HIT;
                    else state_d = S_A_SETUP;
`else
                    state_d = S_A_SETUP;
`endif
                end
            end
            S_A_SETUP:  state_d = S_A_STROBE;
            S_A_STROBE: begin
                if (last_strobe) begin
                    state_d = S_B_SETUP;
                    if (kind_q != K_DWR) lo_d = sram_rdata;
                end
            end
            S_B_SETUP:  state_d = S_B_STROBE;
            S_B_STROBE: begin
                if (last_strobe) begin
                    state_d = S_DONE;
                    if (kind_q == K_DRD) rom_rdata_d = {sram_rdata, lo_q};
                    if (kind_q == K_IRD) begin
                        rom_inst_d = {sram_rdata, lo_q};
`ifdef SRAM_RESP_IBUF_EN
                        ibuf_valid_d = 1'b1;
                        ibuf_addr_d  = addr_q;
`endif
                    end
                end
            end
            S_HIT:      state_d = S_DONE;
            S_DONE: begin
                if (kind_q == K_IRD) begin
                    if (!iread_ce) state_d = S_IDLE;
                end else if (!dread_ce && !dwrite_ce) begin
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase

        cnt_d = '0;
        if ((state_q == S_A_STROBE || state_q == S_B_STROBE) && !last_strobe)
            cnt_d = cnt_q + CNT_W'(1);

        // Pins are registered from the next state so they line up with the state.
        active = (state_d == S_A_SETUP) || (state_d == S_A_STROBE) ||
                 (state_d == S_B_SETUP) || (state_d == S_B_STROBE);
        strobe = (state_d == S_A_STROBE) || (state_d == S_B_STROBE);
        half_b = (state_d == S_B_SETUP) || (state_d == S_B_STROBE);
        is_wr  = (kind_d == K_DWR);
        ce_n_d = !active;
        oe_n_d = !(strobe && !is_wr);
        we_n_d = !(strobe && is_wr);
        dq_oe_d = active && is_wr;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if (active) sram_addr_d = {addr_d[SRAM_AW-2:0], half_b};
        if (active && is_wr) sram_wdata_d = half_b ? wdata_d[31:16] : wdata_d[15:0];

        fin_a_ev = ((state_q == S_A_STROBE) && (state_d == S_B_SETUP)) || (state_d == S_HIT);
        fin_b_ev = (state_d == S_DONE) && (state_q != S_DONE);
        fin_d = {fin_b_ev && (kind_d == K_IRD), fin_a_ev && (kind_d == K_IRD),
                 fin_b_ev && (kind_d == K_DWR), fin_a_ev && (kind_d == K_DWR),
                 fin_b_ev && (kind_d == K_DRD), fin_a_ev && (kind_d == K_DRD)};
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            kind_q       <= K_DRD;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            rom_rdata_q  <= '0;
            rom_inst_q   <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            fin_q        <= '0;
`ifdef SRAM_RESP_IBUF_EN
            ibuf_valid_q <= 1'b0;
            ibuf_addr_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kind_q       <= kind_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            rom_rdata_q  <= rom_rdata_d;
            rom_inst_q   <= rom_inst_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            dq_oe_q      <= dq_oe_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            fin_q        <= fin_d;
`ifdef SRAM_RESP_IBUF_EN
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_addr_q  <= ibuf_addr_d;
`endif
        end
    end

    assign rom_rdata  = rom_rdata_q;
    assign rom_inst   = rom_inst_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign {rfin_d, rfin_c, wfin_b, wfin_a, rfin_b, rfin_a} = fin_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: SRAM model, table-driven accesses, hand-written
// corner sequences and a scoreboard of expected words.
module tb_sram_responder;
    localparam int W  = 2;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dread_ce = 1'b0, dwrite_ce = 1'b0, iread_ce = 1'b0;
    logic [31:0]   drom_addr = '0, wdata = '0, irom_addr = '0;
    logic [31:0]   rom_rdata, rom_inst;
    logic          rfin_a, rfin_b, wfin_a, wfin_b, rfin_c, rfin_d;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_wdata, sram_rdata;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [2:0]    dbg_state;

    sram_responder #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .dread_ce(dread_ce), .dwrite_ce(dwrite_ce), .drom_addr(drom_addr), .wdata(wdata),
        .rom_rdata(rom_rdata), .rfin_a(rfin_a), .rfin_b(rfin_b), .wfin_a(wfin_a), .wfin_b(wfin_b),
        .iread_ce(iread_ce), .irom_addr(irom_addr), .rom_inst(rom_inst),
        .rfin_c(rfin_c), .rfin_d(rfin_d),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // SRAM model: read contents are preloaded by the bench, writes are logged.
    logic [15:0] rd_mem [0:255];
    logic [15:0] wr_log [0:255];
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? rd_mem[sram_addr[7:0]] : 16'h0000;
    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) wr_log[sram_addr[7:0]] <= sram_wdata;

    // Counters and scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_a_q[$];

    // Per-access observations, index = cycle after the accepting edge
    int          first_fin [6];
    int          cnt_fin [6];
    int          ce_low, oe_cnt;
    logic [2:0]  st_log [0:63];
    logic [3:0]  str_log [0:63];
    logic [AW-1:0] addr_log [0:63];

    typedef struct {
        int          kind;   // 0 data read, 1 data write, 2 instruction read
        logic [31:0] addr;
        logic [31:0] wd;
        logic [15:0] lo;
        logic [15:0] hi;
        int          hold;
        logic [31:0] exp;
    } vec_t;
    localparam int NV = 8;
    vec_t vecs [NV];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Pops one expected word when a port reports completion.
    task automatic sb_pop(input string name, input int sel);
        logic [31:0] e, act;
        logic [7:0]  a, a1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: completion with empty expected queue", name);
        end else begin
            e  = exp_q.pop_front();
            a  = exp_a_q.pop_front();
            a1 = a + 8'd1;
            case (sel)
                0: act = rom_rdata;
                1: act = rom_inst;
                default: act = {wr_log[a1], wr_log[a]};
            endcase
            chk(name, act, e);
        end
    endtask

    task automatic sample(input int c);
        logic [5:0] fins;
        fins = {rfin_d, rfin_c, wfin_b, wfin_a, rfin_b, rfin_a};
        for (int i = 0; i < 6; i++) begin
            if (fins[i]) begin
                cnt_fin[i]++;
                if (first_fin[i] == 0) first_fin[i] = c;
            end
        end
        if (!sram_ce_n) ce_low++;
        if (sram_dq_oe) oe_cnt++;
        st_log[c]   = dbg_state;
        str_log[c]  = {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
        addr_log[c] = sram_addr;
        if (rfin_b) sb_pop("rom_rdata", 0);
        if (rfin_d) sb_pop("rom_inst", 1);
        if (wfin_b) sb_pop("sram_write_word", 2);
    endtask

    // Driver: raise requests, then observe cycles 1..ncyc after the accepting edge.
    task automatic go(input logic [2:0] ce_mask, input int ncyc, input int drop_cyc,
                      input logic [2:0] drop_mask, input int rst_cyc);
        @(posedge clk);
        #1;
        dread_ce  = ce_mask[0];
        dwrite_ce = ce_mask[1];
        iread_ce  = ce_mask[2];
        for (int i = 0; i < 6; i++) begin
            first_fin[i] = 0;
            cnt_fin[i]   = 0;
        end
        ce_low = 0;
        oe_cnt = 0;
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            sample(c);
            if (c == drop_cyc) begin
                if (drop_mask[0]) dread_ce  = 1'b0;
                if (drop_mask[1]) dwrite_ce = 1'b0;
                if (drop_mask[2]) iread_ce  = 1'b0;
            end
            if (c == rst_cyc) rst = 1'b1;
            if (c == rst_cyc + 1) rst = 1'b0;
        end
    endtask

    // Timing and exclusivity checks for one SRAM-backed access.
    task automatic check_timing(input int kind, input int ncyc);
        int a, others;
        a = (kind == 0) ? 0 : (kind == 1) ? 2 : 4;
        others = 0;
        for (int i = 0; i < 6; i++) if (i != a && i != a + 1) others += cnt_fin[i];
        chk("fin_a_cycle", first_fin[a], W + 2);
        chk("fin_b_cycle", first_fin[a+1], 2*W + 3);
        chk("fin_a_count", cnt_fin[a], 1);
        chk("fin_b_count", cnt_fin[a+1], 1);
        chk("other_fins", others, 0);
        chk("ce_low_cycles", ce_low, 2*W + 2);
        chk("dq_oe_cycles", oe_cnt, (kind == 1) ? 2*W + 2 : 0);
        chk("idle_after_drop", st_log[ncyc], 0);
    endtask

    task automatic preload(input logic [31:0] addr, input logic [15:0] lo, input logic [15:0] hi);
        logic [7:0] h;
        h = {addr[8:2], 1'b0};
        rd_mem[h] = lo;
        rd_mem[h + 8'd1] = hi;
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] word);
        exp_q.push_back(word);
        exp_a_q.push_back({addr[8:2], 1'b0});
    endtask

    initial begin
        vec_t v;
        logic [2:0] mask;
        int nc;
        logic [31:0] rw;

        for (int i = 0; i < 256; i++) begin
            rd_mem[i] = 16'h0;
            wr_log[i] = 16'h0;
        end
        rw = $urandom_range(32'h7fff_ffff, 0);
        vecs[0] = '{0, 32'h08, 32'h0, 16'h1111, 16'h2222, 0, 32'h2222_1111};
        vecs[1] = '{1, 32'h10, 32'hDEAD_BEEF, 16'h0, 16'h0, 0, 32'hDEAD_BEEF};
        vecs[2] = '{2, 32'h20, 32'h0, 16'h5678, 16'h1234, 0, 32'h1234_5678};
        vecs[3] = '{0, 32'h0B, 32'h0, 16'hA5A5, 16'h5A5A, 0, 32'h5A5A_A5A5};
        vecs[4] = '{1, 32'h1E, 32'h0F0F_F0F0, 16'h0, 16'h0, 0, 32'h0F0F_F0F0};
        vecs[5] = '{2, 32'h30, 32'h0, 16'hCAFE, 16'hF00D, 20, 32'hF00D_CAFE};
        vecs[6] = '{0, 32'h3C, 32'h0, rw[15:0], rw[31:16], 20, rw};
        rw = $urandom_range(32'h7fff_ffff, 0);
        vecs[7] = '{1, 32'h44, rw, 16'h0, 16'h0, 0, rw};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        chk("rst_fins", {rfin_a, rfin_b, wfin_a, wfin_b, rfin_c, rfin_d}, 6'b0);
        chk("rst_rom_rdata", rom_rdata, 0);
        chk("rst_rom_inst", rom_inst, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table of single accesses
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            drom_addr = v.addr;
            irom_addr = v.addr;
            wdata     = v.wd;
            preload(v.addr, v.lo, v.hi);
            push_exp(v.addr, v.exp);
            mask = (v.kind == 0) ? 3'b001 : (v.kind == 1) ? 3'b010 : 3'b100;
            nc = 2*W + 4 + v.hold;
            go(mask, nc, nc - 1, 3'b111, -10);
            check_timing(v.kind, nc);
        end

        // Data and instruction requests raised together: data first
        drom_addr = 32'h50;
        irom_addr = 32'h60;
        preload(32'h50, 16'h3333, 16'h4444);
        preload(32'h60, 16'h7777, 16'h8888);
        push_exp(32'h50, 32'h4444_3333);
        push_exp(32'h60, 32'h8888_7777);
        go(3'b101, 17, 7, 3'b001, -10);
        chk("both_rfin_a", first_fin[0], W + 2);
        chk("both_rfin_b", first_fin[1], 2*W + 3);
        chk("both_rfin_c", first_fin[4], 2*W + 3 + 1 + W + 2);
        chk("both_rfin_d", first_fin[5], 2*W + 3 + 1 + 2*W + 3);
        chk("both_ce_low", ce_low, 4*W + 4);
        chk("both_wfins", cnt_fin[2] + cnt_fin[3], 0);
        iread_ce = 1'b0;
        @(negedge clk);
        chk("both_idle", dbg_state, 0);

        // Request dropped mid-access still completes; DONE exits at once
        drom_addr = 32'h70;
        preload(32'h70, 16'h9999, 16'hAAAA);
        push_exp(32'h70, 32'hAAAA_9999);
        go(3'b001, 2*W + 4, 2, 3'b001, -10);
        check_timing(0, 2*W + 4);

        // Reset during A_STROBE of a write
        drom_addr = 32'h80;
        wdata     = 32'h1234_ABCD;
        go(3'b010, 10, 2, 3'b010, 2);
        chk("mid_rst_strobe_before", str_log[2], 4'b0101);
        chk("mid_rst_strobes", str_log[3], 4'b1110);
        chk("mid_rst_state", st_log[3], 0);
        chk("mid_rst_addr", addr_log[3], 0);
        chk("mid_rst_fins", cnt_fin[0] + cnt_fin[1] + cnt_fin[2] + cnt_fin[3] + cnt_fin[4] + cnt_fin[5], 0);
        chk("mid_rst_idle", st_log[10], 0);

        // Repeated instruction read, then a write, then the same read again
        irom_addr = 32'h40;
        preload(32'h40, 16'hAAAA, 16'hBBBB);
        push_exp(32'h40, 32'hBBBB_AAAA);
        go(3'b100, 2*W + 4, 2*W + 3, 3'b100, -10);
        check_timing(2, 2*W + 4);
        push_exp(32'h40, 32'hBBBB_AAAA);
`ifdef SRAM_RESP_IBUF_EN
        go(3'b100, 3, 2, 3'b100, -10);
        chk("hit_rfin_c", first_fin[4], 1);
        chk("hit_rfin_d", first_fin[5], 2);
        chk("hit_ce_low", ce_low, 0);
        chk("hit_idle", st_log[3], 0);
`else
        go(3'b100, 2*W + 4, 2*W + 3, 3'b100, -10);
        check_timing(2, 2*W + 4);
`endif
        drom_addr = 32'h100;
        wdata     = 32'h5555_6666;
        push_exp(32'h100, 32'h5555_6666);
        go(3'b010, 2*W + 4, 2*W + 3, 3'b010, -10);
        check_timing(1, 2*W + 4);
        preload(32'h40, 16'hCCCC, 16'hDDDD);
        push_exp(32'h40, 32'hDDDD_CCCC);
        go(3'b100, 2*W + 4, 2*W + 3, 3'b100, -10);
        check_timing(2, 2*W + 4);

        chk("sb_leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
